// File: rtl/uart_cmd_decoder.sv
// Decodes 4-byte UART write frames (SYNC, ADDR, DATA, CHK) into register-write strobes,
// reporting checksum and inter-byte timeout errors on a coded error strobe.
module uart_cmd_decoder #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 12000,
  parameter int         CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rcv,
  input  logic [7:0] data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    GET_CHK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       addr_q;
  logic [7:0]       addr_nxt;
  logic [7:0]       dat_q;
  logic [7:0]       dat_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wr_en_nxt;
  logic [7:0]       wr_addr_nxt;
  logic [7:0]       wr_data_nxt;
  logic             frame_err_nxt;
  logic [1:0]       err_code_nxt;

  // Next-state and next-output logic; data is only looked at when rcv is high.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_q;
    dat_nxt       = dat_q;
    cnt_nxt       = '0;
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    frame_err_nxt = 1'b0;
    err_code_nxt  = err_code;

    case (state)
      IDLE: begin
        if (rcv && (data == SYNC)) begin
          state_nxt = GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (rcv) begin
          addr_nxt  = data;
          state_nxt = GET_DATA;
        end
      end
      GET_DATA: begin
        if (rcv) begin
          dat_nxt   = data;
          state_nxt = GET_CHK;
        end
      end
      GET_CHK: begin
        if (rcv) begin
          state_nxt = IDLE;
          if (data == (addr_q ^ dat_q)) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr_q;
            wr_data_nxt = dat_q;
          end else begin
            frame_err_nxt = 1'b1;
            err_code_nxt  = ERR_CHK;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Inter-byte watchdog: a byte arriving on the terminal count still wins.
    if ((state != IDLE) && !rcv) begin
      if (cnt == TERM_CNT) begin
        state_nxt     = IDLE;
        frame_err_nxt = 1'b1;
        err_code_nxt  = ERR_TO;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      addr_q    <= '0;
      dat_q     <= '0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_q    <= addr_nxt;
      dat_q     <= dat_nxt;
      cnt       <= cnt_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      frame_err <= frame_err_nxt;
      err_code  <= err_code_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: one instance with the default watchdog for
// slow byte spacing, and one with TIMEOUT=50 for the timeout scenarios.
module tb_uart_cmd_decoder;

  logic       clk;
  logic       rstn;
  logic       rcv;
  logic [7:0] data;

  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  logic       to_wr_en;
  logic [7:0] to_wr_addr;
  logic [7:0] to_wr_data;
  logic       to_frame_err;
  logic [1:0] to_err_code;
  logic       to_busy;

  int errors = 0;
  int checks = 0;
  int wr_pulses = 0;
  int err_pulses = 0;
  int to_wr_pulses = 0;
  int to_err_pulses = 0;

  uart_cmd_decoder dut (
    .clk       (clk),
    .rstn      (rstn),
    .rcv       (rcv),
    .data      (data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  uart_cmd_decoder #(.TIMEOUT(50)) dut_to (
    .clk       (clk),
    .rstn      (rstn),
    .rcv       (rcv),
    .data      (data),
    .wr_en     (to_wr_en),
    .wr_addr   (to_wr_addr),
    .wr_data   (to_wr_data),
    .frame_err (to_frame_err),
    .err_code  (to_err_code),
    .busy      (to_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) wr_pulses++;
    if (frame_err === 1'b1) err_pulses++;
    if (to_wr_en === 1'b1) to_wr_pulses++;
    if (to_frame_err === 1'b1) to_err_pulses++;
  end

  // Drives one byte for a single cycle, then leaves data unknown for gap idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rcv  = 1'b1;
    data = b;
    @(negedge clk);
    rcv  = 1'b0;
    data = 'x;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    rcv  = 1'b0;
    data = 'x;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_addr: got %h expected 00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 00", wr_data); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("[TB] FAIL reset_err_code: got %b expected 00", err_code); end
  endtask

  task automatic test_valid_frame();
    int wr0, err0;
    wr0 = wr_pulses;
    err0 = err_pulses;
    send_byte(8'hA5, 1039);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL valid_busy_mid: got %b expected 1", busy); end
    send_byte(8'h10, 1039);
    send_byte(8'h3C, 1039);
    send_byte(8'h2C, 0);
    #1;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL valid_wr_en: got %b expected 1", wr_en); end
    checks++; if (wr_addr !== 8'h10) begin errors++; $display("[TB] FAIL valid_wr_addr: got %h expected 10", wr_addr); end
    checks++; if (wr_data !== 8'h3C) begin errors++; $display("[TB] FAIL valid_wr_data: got %h expected 3c", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL valid_busy_end: got %b expected 0", busy); end
    @(negedge clk); #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL valid_wr_en_width: got %b expected 0", wr_en); end
    checks++; if (wr_pulses - wr0 !== 1) begin errors++; $display("[TB] FAIL valid_wr_count: got %0d expected 1", wr_pulses - wr0); end
    checks++; if (err_pulses - err0 !== 0) begin errors++; $display("[TB] FAIL valid_err_count: got %0d expected 0", err_pulses - err0); end
  endtask

  task automatic test_bad_checksum();
    int wr0, err0;
    wr0 = wr_pulses;
    err0 = err_pulses;
    send_byte(8'hA5, 1);
    send_byte(8'h10, 1);
    send_byte(8'h3C, 1);
    send_byte(8'hFF, 0);
    #1;
    checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL chk_frame_err: got %b expected 1", frame_err); end
    checks++; if (err_code !== 2'b01) begin errors++; $display("[TB] FAIL chk_err_code: got %b expected 01", err_code); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL chk_wr_en: got %b expected 0", wr_en); end
    @(negedge clk); #1;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL chk_frame_err_width: got %b expected 0", frame_err); end
    checks++; if (err_code !== 2'b01) begin errors++; $display("[TB] FAIL chk_err_code_hold: got %b expected 01", err_code); end
    // A second bad frame with different fields shows the outputs really hold.
    send_byte(8'hA5, 1);
    send_byte(8'h55, 1);
    send_byte(8'h66, 1);
    send_byte(8'h00, 0);
    #1;
    checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL chk2_frame_err: got %b expected 1", frame_err); end
    checks++; if (wr_addr !== 8'h10) begin errors++; $display("[TB] FAIL chk2_wr_addr_hold: got %h expected 10", wr_addr); end
    checks++; if (wr_data !== 8'h3C) begin errors++; $display("[TB] FAIL chk2_wr_data_hold: got %h expected 3c", wr_data); end
    @(negedge clk); #1;
    checks++; if (wr_pulses - wr0 !== 0) begin errors++; $display("[TB] FAIL chk_wr_count: got %0d expected 0", wr_pulses - wr0); end
    checks++; if (err_pulses - err0 !== 2) begin errors++; $display("[TB] FAIL chk_err_count: got %0d expected 2", err_pulses - err0); end
  endtask

  task automatic test_garbage();
    int wr0, err0;
    wr0 = wr_pulses;
    err0 = err_pulses;
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h5A, 1);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL garbage_busy: got %b expected 0", busy); end
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h03, 0);
    #1;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL garbage_wr_en: got %b expected 1", wr_en); end
    checks++; if (wr_addr !== 8'h01) begin errors++; $display("[TB] FAIL garbage_wr_addr: got %h expected 01", wr_addr); end
    checks++; if (wr_data !== 8'h02) begin errors++; $display("[TB] FAIL garbage_wr_data: got %h expected 02", wr_data); end
    @(negedge clk); #1;
    checks++; if (wr_pulses - wr0 !== 1) begin errors++; $display("[TB] FAIL garbage_wr_count: got %0d expected 1", wr_pulses - wr0); end
    checks++; if (err_pulses - err0 !== 0) begin errors++; $display("[TB] FAIL garbage_err_count: got %0d expected 0", err_pulses - err0); end
  endtask

  task automatic test_timeout();
    int first_k;
    int err0;
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h07, 0);
    first_k = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk); #1;
      if (to_frame_err === 1'b1) begin
        first_k = k;
        break;
      end
    end
    checks++; if (first_k !== 50) begin errors++; $display("[TB] FAIL timeout_latency: got %0d cycles expected 50", first_k); end
    checks++; if (to_err_code !== 2'b10) begin errors++; $display("[TB] FAIL timeout_err_code: got %b expected 10", to_err_code); end
    checks++; if (to_busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy: got %b expected 0", to_busy); end
    @(negedge clk); #1;
    checks++; if (to_frame_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_width: got %b expected 0", to_frame_err); end
    // Each following byte lands exactly on the terminal count, where rcv must win.
    err0 = to_err_pulses;
    send_byte(8'hA5, 49);
    send_byte(8'h01, 49);
    send_byte(8'h01, 49);
    send_byte(8'h00, 0);
    #1;
    checks++; if (to_wr_en !== 1'b1) begin errors++; $display("[TB] FAIL term_wr_en: got %b expected 1", to_wr_en); end
    checks++; if (to_wr_addr !== 8'h01) begin errors++; $display("[TB] FAIL term_wr_addr: got %h expected 01", to_wr_addr); end
    checks++; if (to_wr_data !== 8'h01) begin errors++; $display("[TB] FAIL term_wr_data: got %h expected 01", to_wr_data); end
    checks++; if (to_err_pulses - err0 !== 0) begin errors++; $display("[TB] FAIL term_err_count: got %0d expected 0", to_err_pulses - err0); end
  endtask

  task automatic test_mid_reset();
    int wr0, err0;
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h22, 0);
    wr0 = wr_pulses;
    err0 = err_pulses;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    send_byte(8'h33, 0);
    send_byte(8'h11, 2);
    #1;
    checks++; if (wr_pulses - wr0 !== 0) begin errors++; $display("[TB] FAIL midrst_wr_count: got %0d expected 0", wr_pulses - wr0); end
    checks++; if (err_pulses - err0 !== 0) begin errors++; $display("[TB] FAIL midrst_err_count: got %0d expected 0", err_pulses - err0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("[TB] FAIL midrst_wr_addr: got %h expected 00", wr_addr); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("[TB] FAIL midrst_err_code: got %b expected 00", err_code); end
    send_byte(8'hA5, 1);
    send_byte(8'h40, 1);
    send_byte(8'h41, 1);
    send_byte(8'h01, 0);
    #1;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL midrst_wr_en: got %b expected 1", wr_en); end
    checks++; if (wr_addr !== 8'h40) begin errors++; $display("[TB] FAIL midrst_wr_addr2: got %h expected 40", wr_addr); end
    checks++; if (wr_data !== 8'h41) begin errors++; $display("[TB] FAIL midrst_wr_data2: got %h expected 41", wr_data); end
  endtask

  task automatic test_back_to_back();
    int wr0, err0;
    do_reset();
    wr0 = wr_pulses;
    err0 = err_pulses;
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h03, 0);
    #1;
    checks++; if ((wr_en !== 1'b1) || (wr_addr !== 8'h01) || (wr_data !== 8'h02)) begin
      errors++; $display("[TB] FAIL b2b_first: got en=%b addr=%h data=%h expected en=1 addr=01 data=02", wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
    send_byte(8'hA5, 1);
    send_byte(8'h04, 1);
    send_byte(8'h05, 1);
    send_byte(8'h01, 0);
    #1;
    checks++; if ((wr_en !== 1'b1) || (wr_addr !== 8'h04) || (wr_data !== 8'h05)) begin
      errors++; $display("[TB] FAIL b2b_second: got en=%b addr=%h data=%h expected en=1 addr=04 data=05", wr_en, wr_addr, wr_data);
    end
    // Continuous rcv: the next SYNC arrives in the very cycle wr_en is high.
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    #1;
    checks++; if ((wr_en !== 1'b1) || (wr_addr !== 8'h11) || (wr_data !== 8'h22)) begin
      errors++; $display("[TB] FAIL b2b_burst1: got en=%b addr=%h data=%h expected en=1 addr=11 data=22", wr_en, wr_addr, wr_data);
    end
    send_byte(8'hA5, 0);
    #1;
    checks++; if ((busy !== 1'b1) || (wr_en !== 1'b0)) begin
      errors++; $display("[TB] FAIL b2b_resync: got busy=%b en=%b expected busy=1 en=0", busy, wr_en);
    end
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h11, 0);
    #1;
    checks++; if ((wr_en !== 1'b1) || (wr_addr !== 8'h44) || (wr_data !== 8'h55)) begin
      errors++; $display("[TB] FAIL b2b_burst2: got en=%b addr=%h data=%h expected en=1 addr=44 data=55", wr_en, wr_addr, wr_data);
    end
    @(negedge clk); #1;
    checks++; if (wr_pulses - wr0 !== 4) begin errors++; $display("[TB] FAIL b2b_wr_count: got %0d expected 4", wr_pulses - wr0); end
    checks++; if (err_pulses - err0 !== 0) begin errors++; $display("[TB] FAIL b2b_err_count: got %0d expected 0", err_pulses - err0); end
  endtask

  initial begin
    rstn = 1'b0;
    rcv  = 1'b0;
    data = 'x;
    @(negedge clk);
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_garbage();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Consumes the byte stream from the UART receiver (1-cycle `rcv` strobe plus 8-bit `data`) and decodes fixed 4-byte binary write frames: SYNC, ADDR, DATA, CHK. A valid frame produces a single-cycle register-write strobe toward the system register bank. Bad checksums and inter-byte timeouts are reported on an error strobe with a code. Sits directly downstream of the serial receiver, in the same `clk` domain.

Parameters:
SYNC, 8'hA5, frame start byte
TIMEOUT, 12000, max clk cycles allowed between consecutive bytes of one frame (1 ms at 12 MHz); legal range 2..65535
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock
rstn  in  1  reset; synchronous, active-low
rcv  in  1  byte-valid strobe, exactly 1 cycle per received byte
data  in  8  received byte; sampled only when rcv=1
wr_en  out  1  1-cycle write strobe for a valid frame
wr_addr  out  8  address of the last valid frame
wr_data  out  8  data of the last valid frame
frame_err  out  1  1-cycle error strobe
err_code  out  2  01 = checksum error, 10 = timeout; valid during frame_err, holds afterwards
busy  out  1  1 while a frame is in progress (state != IDLE)

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE.
  - wr_en, frame_err, busy, wr_addr, wr_data, err_code all 0.
  - Timeout counter cleared.
  - Mid-frame reset discards the partial frame and emits no strobe.
- All outputs are registered. No combinational path from rcv/data to any output.
- FSM states: IDLE, GET_ADDR, GET_DATA, GET_CHK.
  - IDLE: on rcv and data==SYNC, go to GET_ADDR. Any other byte is silently dropped with no error.
  - GET_ADDR: on rcv, latch data into an internal addr register and go to GET_DATA. A SYNC value is accepted as an address; there is no resync.
  - GET_DATA: on rcv, latch data into an internal data register and go to GET_CHK.
  - GET_CHK: on rcv, go to IDLE.
    - If data == (addr XOR dat): in the next cycle, wr_en=1 and wr_addr/wr_data take the new values.
    - Otherwise: in the next cycle, frame_err=1, err_code=01, and wr_addr/wr_data are unchanged.
- Latency: wr_en or frame_err rises exactly 1 cycle after the rcv cycle of the CHK byte and lasts exactly 1 cycle.
- wr_addr/wr_data change only on a valid frame and hold between frames.
- Timeout counter:
  - Cleared on entry to GET_ADDR and on every accepted rcv.
  - Increments every cycle in GET_ADDR, GET_DATA and GET_CHK.
  - When it reaches TIMEOUT-1 with no rcv that cycle: go to IDLE, and in the next cycle frame_err=1, err_code=10.
  - If rcv coincides with the terminal count, rcv wins and the byte is processed normally.
- A byte arriving in the cycle the FSM has just returned to IDLE (while wr_en/frame_err is high) is processed normally, so back-to-back frames are supported.
- rcv in IDLE in the same cycle as a timeout strobe is processed normally.
- busy is registered: 1 starting the cycle after SYNC is accepted; 0 starting the cycle after the FSM returns to IDLE.
- rcv=0 means data is don't-care; X on data while rcv=0 must not propagate.

Test Plan:
- Valid frame A5,10,3C,2C (bytes spaced 1040 cycles) → one wr_en pulse, 1 cycle after the CHK rcv; wr_addr=10, wr_data=3C; frame_err stays 0; busy back to 0.
- Bad checksum A5,10,3C,FF → frame_err pulse, err_code=01, no wr_en; wr_addr/wr_data retain previous values.
- Garbage 00,FF,5A then A5,01,02,03 → garbage ignored with no errors; single wr_en with addr=01, data=02.
- TIMEOUT=50: send A5,07 then idle → frame_err exactly 50 cycles after the 07 rcv, err_code=10; next frame A5,01,01,00 → wr_en, addr=01, data=01.
- Reset mid-frame: A5,22, then assert rstn=0 for 1 cycle, then 33,11 → no strobes; all outputs 0; following valid frame decodes correctly.
- Back-to-back frames with rcv every 2 cycles: A5,01,02,03,A5,04,05,01 → two wr_en pulses (01/02, then 04/05), no errors.
